// File: rtl/hmm_pkg.sv
// Shared types and helpers for the keyword-spotter frame decision back-end.
package hmm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_SCAN,
    ST_OUT
  } state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/ll_window_acc.sv
// One model's sliding-window accumulator: WIN-deep circular history plus a running signed sum.
module ll_window_acc
  import hmm_pkg::*;
#(
  parameter int unsigned LL_W  = 32,
  parameter int unsigned WIN   = 8,
  parameter int unsigned ACC_W = LL_W + clog2(WIN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             update,
  input  logic [LL_W-1:0]  sample,
  output logic [ACC_W-1:0] sum,
  output logic             primed
);

  localparam int unsigned       PTR_W     = clog2(WIN);
  localparam int unsigned       FILL_W    = clog2(WIN + 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(WIN - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIN);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIN - 1);

  logic [LL_W-1:0]   buf_q [WIN];
  logic [PTR_W-1:0]  wptr;
  logic [FILL_W-1:0] fill;
  logic [ACC_W-1:0]  add_term;
  logic [ACC_W-1:0]  sub_term;

  always_comb begin
    add_term = {{(ACC_W - LL_W){sample[LL_W-1]}}, sample};
    sub_term = '0;
    if (fill == FILL_FULL) begin
      sub_term = {{(ACC_W - LL_W){buf_q[wptr][LL_W-1]}}, buf_q[wptr]};
    end
  end

  // High when the pending update brings the window to WIN frames.
  assign primed = (fill >= FILL_LAST);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      sum  <= '0;
      wptr <= '0;
      fill <= '0;
    end else if (update) begin
      sum  <= sum + add_term - sub_term;
      wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
      if (fill != FILL_FULL) begin
        fill <= fill + 1'b1;
      end
    end
  end

  // History is never cleared; fill gating keeps stale entries out of the sum.
  always_ff @(posedge clk) begin
    if (update && !reset && !flush) begin
      buf_q[wptr] <= sample;
    end
  end

endmodule

// File: rtl/hmm_frame_decider.sv
// Per-frame argmax over NUM_MODELS sliding-window likelihood sums, with keyword decision.
module hmm_frame_decider
  import hmm_pkg::*;
#(
  parameter  int unsigned NUM_MODELS = 3,
  parameter  int unsigned LL_W       = 32,
  parameter  int unsigned WIN        = 8,
  parameter  int unsigned WORD_IDX   = 0,
  parameter  int unsigned THRESH     = 0,
  localparam int unsigned ACC_W      = LL_W + clog2(WIN),
  localparam int unsigned IDX_W      = clog2(NUM_MODELS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [NUM_MODELS*LL_W-1:0] ll_i,
  input  logic [NUM_MODELS-1:0]      ll_dv,
  output logic                       busy,
  output logic                       overrun,
  output logic                       result_dv,
  output logic [IDX_W-1:0]           result_idx,
  output logic [ACC_W:0]             result_margin,
  output logic                       result_word
);

  localparam logic [IDX_W-1:0] SCAN_LAST = IDX_W'(NUM_MODELS - 1);
  localparam logic [IDX_W-1:0] WORD_C    = IDX_W'(WORD_IDX);
  localparam logic [ACC_W:0]   THRESH_C  = (ACC_W + 1)'(THRESH);

  state_t                   state;
  logic                     clear;
  logic                     do_update;
  logic [NUM_MODELS-1:0]    held;
  logic [NUM_MODELS-1:0]    primed;
  logic [LL_W-1:0]          hold [NUM_MODELS];
  logic [ACC_W-1:0]         sums [NUM_MODELS];
  logic [IDX_W-1:0]         scan_cnt;
  logic [IDX_W-1:0]         best_idx;
  logic signed [ACC_W-1:0]  best_sum;
  logic signed [ACC_W-1:0]  second_sum;
  logic signed [ACC_W-1:0]  cur;
  logic [IDX_W-1:0]         nx_idx;
  logic signed [ACC_W-1:0]  nx_best;
  logic signed [ACC_W-1:0]  nx_second;
  logic [ACC_W:0]           margin_n;

  assign clear     = reset || flush;
  assign do_update = (state == ST_UPDATE);
  assign busy      = (state != ST_IDLE);

  genvar g;
  generate
    for (g = 0; g < NUM_MODELS; g++) begin : g_acc
      ll_window_acc #(
        .LL_W  (LL_W),
        .WIN   (WIN),
        .ACC_W (ACC_W)
      ) u_acc (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .update (do_update),
        .sample (hold[g]),
        .sum    (sums[g]),
        .primed (primed[g])
      );
    end
  endgenerate

  // A slot being consumed by UPDATE this cycle may be refilled in the same cycle.
  always_ff @(posedge clk) begin
    if (clear) begin
      held    <= '0;
      overrun <= 1'b0;
    end else begin
      for (int unsigned m = 0; m < NUM_MODELS; m++) begin
        if (ll_dv[m] && (!held[m] || do_update)) begin
          hold[m] <= ll_i[m*LL_W +: LL_W];
          held[m] <= 1'b1;
        end else if (ll_dv[m]) begin
          overrun <= 1'b1;
        end else if (do_update) begin
          held[m] <= 1'b0;
        end
      end
    end
  end

  // Fold the current model into best/second-best; strict '>' keeps the lowest index on ties.
  always_comb begin
    cur       = $signed(sums[scan_cnt]);
    nx_idx    = best_idx;
    nx_best   = best_sum;
    nx_second = second_sum;
    if (scan_cnt == '0) begin
      nx_idx    = '0;
      nx_best   = cur;
      nx_second = cur;
    end else if (cur > best_sum) begin
      nx_idx    = scan_cnt;
      nx_best   = cur;
      nx_second = best_sum;
    end else if ((scan_cnt == IDX_W'(1)) || (cur > second_sum)) begin
      nx_second = cur;
    end
    margin_n = {nx_best[ACC_W-1], nx_best} - {nx_second[ACC_W-1], nx_second};
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state         <= ST_IDLE;
      scan_cnt      <= '0;
      best_idx      <= '0;
      best_sum      <= '0;
      second_sum    <= '0;
      result_dv     <= 1'b0;
      result_idx    <= '0;
      result_margin <= '0;
      result_word   <= 1'b0;
    end else begin
      result_dv <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (&held) begin
            state <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          scan_cnt <= '0;
          state    <= (&primed) ? ST_SCAN : ST_IDLE;
        end
        ST_SCAN: begin
          best_idx   <= nx_idx;
          best_sum   <= nx_best;
          second_sum <= nx_second;
          // The last model is folded combinationally so the result lands on entry to OUT.
          if (scan_cnt == SCAN_LAST) begin
            result_dv     <= 1'b1;
            result_idx    <= nx_idx;
            result_margin <= margin_n;
            result_word   <= (nx_idx == WORD_C) && (margin_n >= THRESH_C);
            state         <= ST_OUT;
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        ST_OUT: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hmm_frame_decider.sv
// Scoreboard bench for hmm_frame_decider with NUM_MODELS=3, WIN=4, WORD_IDX=0, THRESH=100.
module tb_hmm_frame_decider;

  localparam int unsigned N      = 3;
  localparam int unsigned LL_W   = 32;
  localparam int unsigned WIN    = 4;
  localparam int unsigned ACC_W  = 34;
  localparam longint      THRESH = 100;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic [N*LL_W-1:0] ll_i;
  logic [N-1:0]      ll_dv;
  logic              busy;
  logic              overrun;
  logic              result_dv;
  logic [1:0]        result_idx;
  logic [ACC_W:0]    result_margin;
  logic              result_word;

  hmm_frame_decider #(
    .NUM_MODELS (N),
    .LL_W       (LL_W),
    .WIN        (WIN),
    .WORD_IDX   (0),
    .THRESH     (100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .ll_i          (ll_i),
    .ll_dv         (ll_dv),
    .busy          (busy),
    .overrun       (overrun),
    .result_dv     (result_dv),
    .result_idx    (result_idx),
    .result_margin (result_margin),
    .result_word   (result_word)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned idx;
    longint      margin;
    bit          word;
  } exp_t;

  exp_t        exp_q[$];
  longint      hist[WIN][N];
  int unsigned hist_wp;
  int unsigned n_frames;
  int          total = 0;
  int          bad   = 0;
  int          n_dv  = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (result_dv) begin
      n_dv++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result: idx=%0d margin=%0d but no decision was due", result_idx, result_margin);
      end else begin
        e = exp_q.pop_front();
        total++;
        if (32'(result_idx) !== e.idx) begin
          bad++;
          $display("FAIL sb_idx: got %0d want %0d", result_idx, e.idx);
        end
        total++;
        if (longint'(result_margin) !== e.margin) begin
          bad++;
          $display("FAIL sb_margin: got %0d want %0d", result_margin, e.margin);
        end
        total++;
        if (result_word !== e.word) begin
          bad++;
          $display("FAIL sb_word: got %0b want %0b", result_word, e.word);
        end
      end
    end
  end

  task automatic model_clear();
    hist_wp  = 0;
    n_frames = 0;
    exp_q.delete();
    for (int f = 0; f < WIN; f++)
      for (int m = 0; m < N; m++) hist[f][m] = 0;
  endtask

  // Reference: window sums, argmax with lowest index on ties, best minus best-of-the-rest.
  task automatic model_commit(input int a, input int b, input int c);
    longint      s[N];
    longint      second;
    int unsigned best;
    bit          first;
    exp_t        e;
    hist[hist_wp][0] = a;
    hist[hist_wp][1] = b;
    hist[hist_wp][2] = c;
    hist_wp = (hist_wp + 1) % WIN;
    n_frames++;
    if (n_frames >= WIN) begin
      for (int m = 0; m < N; m++) begin
        s[m] = 0;
        for (int f = 0; f < WIN; f++) s[m] += hist[f][m];
      end
      best = 0;
      for (int unsigned m = 1; m < N; m++) if (s[m] > s[best]) best = m;
      first  = 1'b1;
      second = 0;
      for (int unsigned m = 0; m < N; m++) begin
        if (m != best && (first || s[m] > second)) begin
          second = s[m];
          first  = 1'b0;
        end
      end
      e.idx    = best;
      e.margin = s[best] - second;
      e.word   = (best == 0) && (e.margin >= THRESH);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ll(input int a, input int b, input int c);
    ll_i = {c, b, a};
  endtask

  task automatic frame(input int a, input int b, input int c);
    set_ll(a, b, c);
    ll_dv = '1;
    model_commit(a, b, c);
    tick();
    ll_dv = '0;
    repeat (8) tick();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    int n0;
    reset = 1'b1;
    flush = 1'b0;
    ll_dv = '0;
    ll_i  = '0;
    model_clear();
    repeat (3) tick();
    reset = 1'b0;
    total++; if (result_dv !== 1'b0) begin bad++; $display("FAIL reset_dv: got %0b want 0", result_dv); end
    total++; if (result_idx !== 2'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", result_idx); end
    total++; if (result_margin !== '0) begin bad++; $display("FAIL reset_margin: got %0d want 0", result_margin); end
    total++; if (result_word !== 1'b0) begin bad++; $display("FAIL reset_word: got %0b want 0", result_word); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
    n0 = n_dv;
    repeat (3) frame(10, 5, 1);
    total++; if (n_dv !== n0) begin bad++; $display("FAIL warmup_silent: got %0d pulses want 0", n_dv - n0); end
  endtask

  task automatic test_warmup();
    int n0;
    int lat;
    n0  = n_dv;
    lat = 0;
    set_ll(10, 5, 1);
    ll_dv = '1;
    model_commit(10, 5, 1);
    tick();
    ll_dv = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (result_dv === 1'b1) begin
        lat = k;
        break;
      end
    end
    total++; if (lat != N + 2) begin bad++; $display("FAIL latency: got %0d cycles want %0d", lat, N + 2); end
    repeat (6) tick();
    total++; if (n_dv - n0 != 1) begin bad++; $display("FAIL warmup_count: got %0d pulses want 1", n_dv - n0); end
    total++; if (result_margin !== 35'd20) begin bad++; $display("FAIL warmup_margin: got %0d want 20", result_margin); end
    total++; if (result_word !== 1'b0) begin bad++; $display("FAIL warmup_word: got %0b want 0", result_word); end
  endtask

  task automatic test_sliding();
    do_flush();
    repeat (4) frame(200, 50, -10);
    total++; if (result_idx !== 2'd0) begin bad++; $display("FAIL slide_idx_a: got %0d want 0", result_idx); end
    total++; if (result_margin !== 35'd600) begin bad++; $display("FAIL slide_margin_a: got %0d want 600", result_margin); end
    total++; if (result_word !== 1'b1) begin bad++; $display("FAIL slide_word_a: got %0b want 1", result_word); end
    frame(-1000, 50, -10);
    total++; if (result_idx !== 2'd1) begin bad++; $display("FAIL slide_idx_b: got %0d want 1", result_idx); end
    total++; if (result_margin !== 35'd240) begin bad++; $display("FAIL slide_margin_b: got %0d want 240", result_margin); end
    total++; if (result_word !== 1'b0) begin bad++; $display("FAIL slide_word_b: got %0b want 0", result_word); end
  endtask

  task automatic test_tie();
    do_flush();
    repeat (4) frame(7, 7, 3);
    total++; if (result_idx !== 2'd0) begin bad++; $display("FAIL tie_idx: got %0d want 0", result_idx); end
    total++; if (result_margin !== '0) begin bad++; $display("FAIL tie_margin: got %0d want 0", result_margin); end
  endtask

  task automatic test_skew();
    int n0;
    do_flush();
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL flush_overrun: got %0b want 0", overrun); end
    repeat (3) frame(1, 1, 1);
    n0 = n_dv;
    set_ll(30, 20, 0);
    ll_dv = 3'b011;
    tick();
    ll_dv = '0;
    tick();
    set_ll(999, 0, 0);
    ll_dv = 3'b001;
    tick();
    ll_dv = '0;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL skew_overrun: got %0b want 1", overrun); end
    tick();
    tick();
    set_ll(0, 0, 5);
    ll_dv = 3'b100;
    model_commit(30, 20, 5);
    tick();
    ll_dv = '0;
    repeat (10) tick();
    total++; if (n_dv - n0 != 1) begin bad++; $display("FAIL skew_count: got %0d pulses want 1", n_dv - n0); end
    total++; if (result_margin !== 35'd10) begin bad++; $display("FAIL skew_margin: got %0d want 10", result_margin); end
  endtask

  task automatic test_update_capture();
    do_flush();
    repeat (3) frame(0, 0, 0);
    set_ll(10, 20, 30);
    ll_dv = '1;
    model_commit(10, 20, 30);
    tick();
    ll_dv = '0;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL update_busy: got %0b want 1", busy); end
    set_ll(0, 500, 0);
    ll_dv = 3'b010;
    tick();
    ll_dv = '0;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL update_overrun: got %0b want 0", overrun); end
    repeat (8) tick();
    set_ll(40, 0, 60);
    ll_dv = 3'b101;
    model_commit(40, 500, 60);
    tick();
    ll_dv = '0;
    repeat (8) tick();
    total++; if (result_idx !== 2'd1) begin bad++; $display("FAIL update_idx: got %0d want 1", result_idx); end
    total++; if (result_margin !== 35'd430) begin bad++; $display("FAIL update_margin: got %0d want 430", result_margin); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL update_overrun_end: got %0b want 0", overrun); end
  endtask

  task automatic test_clear_mid_scan(input bit use_reset);
    int n0;
    do_flush();
    repeat (3) frame(9, 9, 9);
    set_ll(50, 1, 1);
    ll_dv = '1;
    tick();
    ll_dv = '0;
    tick();
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midscan_busy: got %0b want 1", busy); end
    if (use_reset) reset = 1'b1;
    else flush = 1'b1;
    tick();
    reset = 1'b0;
    flush = 1'b0;
    model_clear();
    n0 = n_dv;
    repeat (10) tick();
    total++; if (n_dv !== n0) begin bad++; $display("FAIL midscan_no_dv: got %0d pulses want 0", n_dv - n0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midscan_idle: got %0b want 0", busy); end
    repeat (3) frame(1, 2, 3);
    total++; if (n_dv !== n0) begin bad++; $display("FAIL midscan_refill: got %0d pulses want 0", n_dv - n0); end
    frame(1, 2, 3);
    total++; if (n_dv - n0 != 1) begin bad++; $display("FAIL midscan_fresh: got %0d pulses want 1", n_dv - n0); end
    total++; if (result_margin !== 35'd4) begin bad++; $display("FAIL midscan_margin: got %0d want 4", result_margin); end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_sliding();
    test_tie();
    test_skew();
    test_update_capture();
    test_clear_mid_scan(1'b0);
    test_clear_mid_scan(1'b1);
    repeat (4) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_decisions: got %0d outstanding want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
